adc_jesd204_pack: RTL
=====================

Name: adc_jesd204_pack

Overview:
- Downstream neighbour of the JESD204 ADC core.
- Takes the per-channel, per-clock sample bundles (adc_enable / adc_valid / adc_data) and compacts the samples of enabled channels into dense, sample-interleaved words.
- Writes those words into the DMA-facing write FIFO.
- Returns the FIFO overflow as adc_dovf for the core's status register.

Parameters:
- NUM_CHANNELS, 4, channel count; must be 1, 2, 4 or 8.
- DATA_PATH_WIDTH, 4, samples per channel per adc_clk.
- SAMPLE_WIDTH, 16, bits per sample (formatted width).

Ports:
- adc_clk  in  1  sole clock.
- adc_rstn  in  1  reset, synchronous, active-low.
- adc_enable  in  NUM_CHANNELS  per-channel enable from the core.
- adc_valid  in  NUM_CHANNELS  per-channel valid; only bit 0 is sampled.
- adc_data  in  NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH  input; channel c, time t at [(c*DATA_PATH_WIDTH+t)*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- adc_dovf  out  1  registered copy of fifo_wr_overflow.
- fifo_wr_en  out  1  packed word strobe.
- fifo_wr_data  out  NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH  packed word.
- fifo_wr_sync  out  1  high with the first word after a (re)start.
- fifo_wr_overflow  in  1  FIFO overflow flag.
- cfg_err  out  1  enable mask unsupported.

Behaviour:
- Reset: adc_rstn=0 at a rising edge clears fifo_wr_en, fifo_wr_sync, fifo_wr_data, adc_dovf and cfg_err to 0. It also clears the phase counter, the stored mask and the partial word.
- Enable count: N = popcount(adc_enable). Supported N is a power of two, 1 ≤ N ≤ NUM_CHANNELS. N=0 or a non-power-of-two sets cfg_err=1 (registered). While cfg_err=1: no writes, phase held at 0.
- Ratio: R = NUM_CHANNELS/N input beats per output word.
- Compaction stage (cycle 1): on adc_valid[0]=1 the block forms an N*DATA_PATH_WIDTH sample vector.
  - Order is time-major: for t=0..DATA_PATH_WIDTH-1, enabled channels in ascending index.
  - Result is registered together with a valid bit.
- Assembly stage (cycle 2): the compacted vector is written into slot k of the output word, at bit offset k*N*DATA_PATH_WIDTH*SAMPLE_WIDTH, where k is the phase counter (0..R-1).
  - When k=R-1: register the completed word into fifo_wr_data, pulse fifo_wr_en for 1 cycle, set k to 0.
  - Otherwise: k increments.
  - Latency: fifo_wr_en rises 2 cycles after the adc_valid beat that completes the word.
- Valid gaps: adc_valid[0]=0 inserts a bubble only; phase and partial word are held, no write.
- Mask change: adc_enable differing from the stored mask at any cycle does all of the following:
  - discards the partial word;
  - resets k to 0;
  - flushes the pipeline valid bits;
  - updates the stored mask;
  - re-evaluates cfg_err.
  The first complete word afterwards carries fifo_wr_sync=1. Words already in stage 2 at the change are discarded, not written.
- First word after reset also carries fifo_wr_sync=1. fifo_wr_sync=0 on every later word.
- R=1 case (all channels enabled): a write occurs every valid beat, with no slot accumulation.
- fifo_wr_data holds its last value when fifo_wr_en=0.
- adc_dovf <= fifo_wr_overflow each cycle (1-cycle delay). It is not sticky; stickiness lives in the core status register.
- Reset mid-word: the partial word is lost, and the next word carries fifo_wr_sync=1.

Decomposition:
- Package adc_jesd204_pack_pkg holds:
  - localparams for word widths (SAMPLE_WIDTH*DATA_PATH_WIDTH, total width);
  - a popcount function;
  - an is_pow2 function;
  - a log2 function for the phase-counter width.
- One sub-module, adc_jesd204_pack_compact: combinational enable-mask routing network plus the stage-1 register. It emits the compacted vector left-aligned, with unused high samples forced to zero.
- Top level holds the phase counter, assembly, mask tracking and sync/err logic.

Test Plan (NUM_CHANNELS=4, DATA_PATH_WIDTH=4, 256-bit word; sample value = 16'h{c}{t}{beat}):
- Reset, then all 4 enabled, adc_valid=1 for 3 beats -> 3 writes, first at cycle 2 with fifo_wr_sync=1. Word 0 low samples are 0x000,0x100,0x200,0x300,0x010,… (time-major interleave). fifo_wr_sync=0 on words 1-2.
- adc_enable=4'b0101, 4 valid beats -> 2 writes, one every 2 beats. Each word = beat0 {ch0,ch2}×4 in low 128 bits, beat1 in high 128 bits.
- adc_enable=4'b0010, valid pattern 1,0,1,1,0,1 -> exactly 1 write, 2 cycles after the 4th valid beat, containing ch1 samples of the 4 valid beats in order.
- adc_enable=4'b0111 -> cfg_err=1 next cycle, no fifo_wr_en for 20 beats. Change to 4'b0011 -> cfg_err=0, next word has fifo_wr_sync=1.
- Mask 4'b0001, 2 valid beats, then change to 4'b0011 -> partial discarded, no write. Next 2 beats give 1 write with fifo_wr_sync=1.
- fifo_wr_overflow pulsed for 3 cycles -> adc_dovf high for exactly the 3 following cycles. adc_rstn=0 mid-word -> all outputs 0, and the next word has fifo_wr_sync=1.

Source files
------------

// File: rtl/adc_jesd204_pack_pkg.sv
// Shared widths and mask helpers for the JESD204 ADC sample packer.
package adc_jesd204_pack_pkg;

    localparam int MAX_CHANNELS        = 8;
    localparam int DEF_NUM_CHANNELS    = 4;
    localparam int DEF_DATA_PATH_WIDTH = 4;
    localparam int DEF_SAMPLE_WIDTH    = 16;
    localparam int DEF_CHANNEL_WIDTH   = DEF_SAMPLE_WIDTH * DEF_DATA_PATH_WIDTH;
    localparam int DEF_WORD_WIDTH      = DEF_NUM_CHANNELS * DEF_CHANNEL_WIDTH;

    function automatic int popcount(input logic [MAX_CHANNELS-1:0] mask);
        int n;
        n = 0;
        for (int i = 0; i < MAX_CHANNELS; i++)
            if (mask[i]) n = n + 1;
        return n;
    endfunction

    function automatic logic is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/adc_jesd204_pack_compact.sv
// Routes the samples of enabled channels into a dense, time-major vector and
// registers it with a valid bit (first pipeline stage of the packer).
module adc_jesd204_pack_compact
    import adc_jesd204_pack_pkg::*;
#(
    parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH,
    parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH
) (
    input  logic                                             adc_clk,
    input  logic                                             adc_rstn,
    input  logic [NUM_CHANNELS-1:0]                          adc_enable,
    input  logic                                             beat_valid,
    input  logic                                             flush,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] adc_data,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] cmp_data,
    output logic                                             cmp_valid
);

    localparam int WORD_W = NUM_CHANNELS * DATA_PATH_WIDTH * SAMPLE_WIDTH;

    logic [WORD_W-1:0] packed_data;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        packed_data = '0;
        idx         = 0;
        for (int t = 0; t < DATA_PATH_WIDTH; t++) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (adc_enable[c]) begin
                    packed_data[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                        adc_data[(c*DATA_PATH_WIDTH+t)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                    idx = idx + 1;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            cmp_valid <= 1'b0;
            cmp_data  <= '0;
        end else begin
            cmp_valid <= beat_valid && !flush;
            if (beat_valid && !flush)
                cmp_data <= packed_data;
        end
    end

endmodule

// File: rtl/adc_jesd204_pack.sv
// Packs enabled ADC channel samples into dense words for the DMA write FIFO,
// tracking mask changes to restart packing and flag the first word with sync.
module adc_jesd204_pack
    import adc_jesd204_pack_pkg::*;
#(
    parameter int NUM_CHANNELS    = DEF_NUM_CHANNELS,
    parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH,
    parameter int SAMPLE_WIDTH    = DEF_SAMPLE_WIDTH
) (
    input  logic                                             adc_clk,
    input  logic                                             adc_rstn,
    input  logic [NUM_CHANNELS-1:0]                          adc_enable,
    input  logic [NUM_CHANNELS-1:0]                          adc_valid,
    input  logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] adc_data,
    output logic                                             adc_dovf,
    output logic                                             fifo_wr_en,
    output logic [NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] fifo_wr_data,
    output logic                                             fifo_wr_sync,
    input  logic                                             fifo_wr_overflow,
    output logic                                             cfg_err
);

    localparam int WORD_W  = NUM_CHANNELS * DATA_PATH_WIDTH * SAMPLE_WIDTH;
    localparam int SAMPLES = NUM_CHANNELS * DATA_PATH_WIDTH;
    localparam int PHASE_W = (NUM_CHANNELS > 1) ? log2_ceil(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] mask_q;
    logic [PHASE_W-1:0]      phase_q;
    logic [PHASE_W-1:0]      last_phase;
    logic [WORD_W-1:0]       partial_q;
    logic [WORD_W-1:0]       assembled;
    logic [WORD_W-1:0]       cmp_data;
    logic                    cmp_valid;
    logic                    sync_pending_q;
    logic                    mask_change;
    logic                    enable_ok;
    logic                    unused_valid_hi;

    // Only lane 0 carries the beat strobe; the other lanes are redundant copies.
    assign unused_valid_hi = ^adc_valid;

    always_comb begin
        int n_active;
        int base;
        int span;
        mask_change = (adc_enable != mask_q);
        enable_ok   = is_pow2(popcount(MAX_CHANNELS'(adc_enable)));
        n_active    = popcount(MAX_CHANNELS'(mask_q));
        last_phase  = PHASE_W'((NUM_CHANNELS >> log2_ceil(n_active)) - 1);
        span        = n_active * DATA_PATH_WIDTH;
        base        = int'(phase_q) * span;
        assembled   = partial_q;
        for (int s = 0; s < SAMPLES; s++) begin
            if (s >= base && s < base + span)
                assembled[s*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                    cmp_data[(s-base)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    adc_jesd204_pack_compact #(
        .NUM_CHANNELS    (NUM_CHANNELS),
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH),
        .SAMPLE_WIDTH    (SAMPLE_WIDTH)
    ) u_compact (
        .adc_clk    (adc_clk),
        .adc_rstn   (adc_rstn),
        .adc_enable (adc_enable),
        .beat_valid (adc_valid[0] && enable_ok),
        .flush      (mask_change),
        .adc_data   (adc_data),
        .cmp_data   (cmp_data),
        .cmp_valid  (cmp_valid)
    );

    // NOTE: the word registers are reset along with control so fifo_wr_data
    // reads a defined zero after reset rather than stale contents.
    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            adc_dovf       <= 1'b0;
            cfg_err        <= 1'b0;
            fifo_wr_en     <= 1'b0;
            fifo_wr_sync   <= 1'b0;
            fifo_wr_data   <= '0;
            mask_q         <= '0;
            phase_q        <= '0;
            partial_q      <= '0;
            sync_pending_q <= 1'b1;
        end else begin
            adc_dovf     <= fifo_wr_overflow;
            cfg_err      <= !enable_ok;
            fifo_wr_en   <= 1'b0;
            fifo_wr_sync <= 1'b0;
            if (mask_change) begin
                // Restart packing: anything in flight belongs to the old layout.
                mask_q         <= adc_enable;
                phase_q        <= '0;
                partial_q      <= '0;
                sync_pending_q <= 1'b1;
            end else if (cmp_valid && !cfg_err) begin
                if (phase_q == last_phase) begin
                    fifo_wr_data   <= assembled;
                    fifo_wr_en     <= 1'b1;
                    fifo_wr_sync   <= sync_pending_q;
                    sync_pending_q <= 1'b0;
                    phase_q        <= '0;
                    partial_q      <= '0;
                end else begin
                    partial_q <= assembled;
                    phase_q   <= phase_q + 1'b1;
                end
            end
        end
    end

endmodule
